// File: rtl/screen_update_scheduler.sv
// Screen-memory write-port scheduler: per game tick, clears the H x V grid,
// streams snake segments, then writes the coin cell. Sole owner of port A.
module screen_update_scheduler #(
  parameter int          H             = 32,
  parameter int          V             = 32,
  parameter logic [1:0]  BG_INDEX      = 2'd0,
  parameter logic [1:0]  SNAKE_INDEX   = 2'd1,
  parameter logic [1:0]  COIN_INDEX    = 2'd2,
  parameter int          SNAKE_TIMEOUT = 2048,
  localparam int         XW            = $clog2(H),
  localparam int         YW            = $clog2(V),
  localparam int         AW            = XW + YW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          game_tick,
  output logic          snake_start,
  input  logic          snake_valid,
  input  logic [XW-1:0] snake_x,
  input  logic [YW-1:0] snake_y,
  input  logic          snake_last,
  output logic          snake_ready,
  input  logic          coin_valid,
  input  logic [XW-1:0] coin_x,
  input  logic [YW-1:0] coin_y,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_data,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun,
  output logic          timeout
);

  localparam int WDW = $clog2(SNAKE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SNAKE = 2'd2,
    COIN  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic [WDW-1:0] wd_q, wd_d;

  logic          mem_we_d, snake_start_d, snake_ready_d;
  logic [AW-1:0] mem_addr_d;
  logic [1:0]    mem_data_d;
  logic          busy_d, frame_done_d, overrun_d, timeout_d;

  // Every output is a register loaded with the value computed for the next
  // cycle, so the write port shows the action decided one cycle earlier.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    wd_d          = wd_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = '0;
    mem_data_d    = '0;
    snake_start_d = 1'b0;
    snake_ready_d = 1'b0;
    busy_d        = 1'b0;
    frame_done_d  = 1'b0;
    overrun_d     = overrun | (game_tick & busy);
    timeout_d     = timeout;

    unique case (state_q)
      IDLE: begin
        // busy is still high for the cycle showing the coin write; a tick
        // there belongs to the finished frame and only flags overrun.
        if (game_tick && !busy) begin
          state_d    = CLEAR;
          cnt_d      = '0;
          mem_we_d   = 1'b1;
          mem_addr_d = '0;
          mem_data_d = BG_INDEX;
          busy_d     = 1'b1;
        end
      end

      CLEAR: begin
        busy_d = 1'b1;
        if (cnt_q == '1) begin
          state_d       = SNAKE;
          snake_start_d = 1'b1;
          wd_d          = '0;
        end else begin
          cnt_d      = cnt_q + AW'(1);
          mem_we_d   = 1'b1;
          mem_addr_d = cnt_q + AW'(1);
          mem_data_d = BG_INDEX;
        end
      end

      SNAKE: begin
        busy_d        = 1'b1;
        snake_ready_d = 1'b1;
        wd_d          = wd_q + WDW'(1);
        if (snake_valid && snake_ready) begin
          mem_we_d   = 1'b1;
          mem_addr_d = {snake_y, snake_x};
          mem_data_d = SNAKE_INDEX;
          if (snake_last) begin
            state_d       = COIN;
            snake_ready_d = 1'b0;
          end
        end
        // A final segment arriving on the watchdog's last cycle wins.
        if (state_d == SNAKE && wd_q == WDW'(SNAKE_TIMEOUT - 1)) begin
          state_d       = COIN;
          snake_ready_d = 1'b0;
          timeout_d     = 1'b1;
        end
      end

      COIN: begin
        busy_d       = 1'b1;
        state_d      = IDLE;
        mem_we_d     = coin_valid;
        mem_addr_d   = {coin_y, coin_x};
        mem_data_d   = COIN_INDEX;
        frame_done_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wd_q        <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      snake_start <= 1'b0;
      snake_ready <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // of the previous cycle regardless of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_data    <= mem_data_d;
      snake_start <= snake_start_d;
      snake_ready <= snake_ready_d;
      busy        <= busy_d;
      frame_done  <= frame_done_d;
      overrun     <= overrun_d;
      timeout     <= timeout_d;
    end
  end

endmodule

// File: doc/screen_update_scheduler.md
Name: screen_update_scheduler

Overview:
- Sequences every game-tick redraw of the H×V cell screen memory write port.
- Phases, in order: full clear sweep, then snake-segment stream, then a single coin write.
- Owns the only write port, so the clear counter, snake stream and coin request never collide.
- Sits between the game-tick source, the snake/coin position blocks and the dual-port screen memory (port A).

Parameters:
H, 32, grid width in cells; power of two
V, 32, grid height in cells; power of two
BG_INDEX, 0, 2-bit colour index written during clear
SNAKE_INDEX, 1, 2-bit index written for snake segments
COIN_INDEX, 2, 2-bit index written for coin
SNAKE_TIMEOUT, 2048, max cycles allowed in SNAKE phase

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
game_tick  in  1  one-cycle pulse; starts a redraw
snake_start  out  1  one-cycle pulse; tells snake block to begin shifting out segments
snake_valid  in  1  segment coordinate valid
snake_x  in  log2(H)  segment column
snake_y  in  log2(V)  segment row
snake_last  in  1  marks final segment (qualified by snake_valid)
snake_ready  out  1  scheduler accepts segment
coin_valid  in  1  coin present
coin_x  in  log2(H)  coin column
coin_y  in  log2(V)  coin row
mem_we  out  1  screen memory write enable
mem_addr  out  log2(H*V)  write address
mem_data  out  2  write colour index
busy  out  1  high while not IDLE
frame_done  out  1  one-cycle pulse at end of COIN phase
overrun  out  1  sticky: game_tick arrived while busy
timeout  out  1  sticky: SNAKE phase aborted by watchdog

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, all outputs 0, clear counter 0, watchdog 0.
- All outputs are registered.
- Address rule: mem_addr = y*H + x, computed as the concatenation {y,x}, width log2(H)+log2(V). No truncation is possible because H and V are powers of two.
- States: IDLE, CLEAR, SNAKE, COIN.
- IDLE:
  - mem_we=0, snake_ready=0.
  - game_tick=1 → CLEAR with counter=0.
- CLEAR:
  - Each cycle: mem_we=1, mem_addr=counter, mem_data=BG_INDEX; counter increments.
  - Sweep takes exactly H*V cycles, addresses 0..H*V-1, no gaps.
  - On the cycle that writes H*V-1 → SNAKE; snake_start pulses high for the first SNAKE cycle.
- SNAKE:
  - snake_ready=1 every cycle except the first (the snake_start cycle).
  - Handshake is snake_valid & snake_ready. On handshake, the next cycle drives mem_we=1, mem_addr={snake_y,snake_x}, mem_data=SNAKE_INDEX (1-cycle latency).
  - No handshake → mem_we=0 next cycle.
  - Handshake with snake_last=1 → COIN on the next cycle; snake_ready drops on that same next cycle.
  - Watchdog counts cycles in SNAKE. Reaching SNAKE_TIMEOUT without snake_last → set timeout, go COIN.
- COIN (exactly 1 cycle):
  - mem_we=coin_valid, mem_addr={coin_y,coin_x}, mem_data=COIN_INDEX.
  - frame_done=1; → IDLE next cycle.
  - coin_valid=0 → no write, frame_done still pulses.
- busy=1 in CLEAR, SNAKE and COIN.
- game_tick while busy:
  - Ignored; redraw is not restarted; overrun is set.
  - overrun and timeout clear only on reset.
  - game_tick in the same cycle COIN→IDLE is also ignored (state is not IDLE in that cycle).
- snake_valid outside SNAKE is ignored.
- coin_valid outside COIN is ignored.
- Reset mid-operation: immediate return to IDLE; the partial frame is left in memory; no frame_done.

Test Plan:
- Reset then idle 10 cycles, no tick → mem_we, busy, frame_done, snake_ready, overrun, timeout all 0.
- H=V=32, tick → 1024 consecutive mem_we cycles, addr 0..1023, data 0; snake_start pulses the cycle after addr 1023.
- Snake segments (5,3),(4,3),(3,3), last on third, coin_valid=1 at (10,20) → writes addr 101,100,99 with data 1, then addr 650 with data 2; frame_done the same cycle as the coin write; busy low the following cycle.
- snake_valid toggled 1,0,1 with last on second valid → exactly two snake writes; no write in the gap cycle.
- Second game_tick 200 cycles into CLEAR → sweep continues uninterrupted to addr 1023; overrun=1 and stays 1 after frame_done.
- snake_valid held 0, SNAKE_TIMEOUT=16 → COIN entered 16 cycles after SNAKE entry; timeout=1; frame_done pulses.
- Reset asserted at clear addr 500 → all outputs 0 asynchronously; a subsequent tick restarts the sweep at addr 0.
